ps2_key_receiver: RTL and testbench
===================================

Name: ps2_key_receiver

Overview:
- Upstream stage of the image-convolution system: receives PS/2 keyboard frames and decodes them into the key_pressed/key_flag pair the processor uses to choose image, kernel and music.
- Runs on the processor clock domain.
- Resynchronises and filters the asynchronous PS/2 lines, deframes 11-bit frames, and strips break (F0) and extended (E0) prefixes.
- Optionally suppresses typematic repeats so each physical key press yields exactly one key_flag.

Parameters:
- FILTER_LEN, 4, consecutive identical synchronised ps2_clk samples required before a level change is accepted.
- TIMEOUT_CYCLES, 50000, clk cycles without a ps2_clk falling edge before an in-progress frame is aborted (1 ms at 50 MHz).
- SUPPRESS_REPEAT, 1, 1 = ignore repeated make codes of the currently held key; 0 = flag every make code.

Ports:
- clk  input  1  processor clock.
- rst  input  1  reset; synchronous, active-low.
- ps2_clk  input  1  raw PS/2 clock line, asynchronous.
- ps2_data  input  1  raw PS/2 data line, asynchronous.
- key_pressed  output  8  last accepted make code; held until the next accepted make code.
- key_flag  output  1  one-cycle pulse when key_pressed is updated.
- key_ext  output  1  1 if the last accepted make code was E0-prefixed; updated together with key_pressed.
- frame_err  output  1  one-cycle pulse on parity, start, stop or timeout error.

Behaviour:
- Reset (rst==0 at a clk edge): key_pressed=8'h00, key_flag=0, key_ext=0, frame_err=0, FSM=IDLE, bit counter=0, timeout counter=0, break_pending=0, ext_pending=0, held_code=8'h00, held_valid=0, filtered ps2_clk=1. Reset mid-frame discards the partial frame with no error pulse.
- Input sync: 2-flop synchroniser on each PS/2 line.
- Clock filter: filtered ps2_clk toggles only after FILTER_LEN consecutive synchronised samples differ from its current value.
- Falling edge: filtered clk goes 1->0. ps2_data (synchronised) is sampled in that same cycle.
- FSM states and transitions:
  - IDLE: on a falling edge with data==0, go to DATA with bit counter 0. With data==1, stay in IDLE and pulse frame_err.
  - DATA: shift in 8 bits, LSB first. After bit 7, go to PARITY.
  - PARITY: store the bit, go to STOP.
  - STOP: the frame is valid iff stop bit==1 and popcount(data,parity) is odd. Valid: emit the byte to the decoder. Invalid: pulse frame_err. Either way, return to IDLE.
- Timeout:
  - The counter clears on every falling edge and while in IDLE; otherwise it increments.
  - On reaching TIMEOUT_CYCLES-1 outside IDLE: go to IDLE, pulse frame_err, clear the bit counter.
  - Timeout takes priority over a falling edge in the same cycle.
- Decoder, acting on each valid byte:
  - 8'hF0: set break_pending. No output change.
  - 8'hE0: set ext_pending. No output change.
  - Other code c with break_pending=1: release. If held_valid and c==held_code, clear held_valid. No key_flag. Clear both pendings.
  - Other code c with break_pending=0:
    - If SUPPRESS_REPEAT=1, held_valid=1 and c==held_code: no flag.
    - Otherwise: key_pressed<=c, key_ext<=ext_pending, key_flag=1 for one cycle, held_code<=c, held_valid<=1.
    - In both cases, clear ext_pending.
- Latency: key_flag and key_pressed update exactly 1 clk after the cycle in which the stop-bit falling edge is detected. frame_err has the same latency.
- Error frames do not modify break_pending, ext_pending, held_code or any output except frame_err.
- key_flag and frame_err are never asserted in the same cycle. Neither is ever high for more than one cycle.
- The timeout counter is sized ceil(log2(TIMEOUT_CYCLES)) bits and never wraps.

Test Plan:
- Make code: frame 0x1C (start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1) -> key_pressed=8'h1C, key_ext=0, key_flag high exactly one cycle, 1 clk after the stop edge; frame_err never high.
- Break and repeat: with SUPPRESS_REPEAT=1, send 1C,1C,1C,F0,1C,1C -> exactly two key_flag pulses (first and last 1C); key_pressed=8'h1C throughout. Same sequence with SUPPRESS_REPEAT=0 -> four pulses.
- Extended key: send E0,75 -> key_pressed=8'h75, key_ext=1, one flag. Then send 29 -> key_pressed=8'h29, key_ext=0.
- Parity and stop errors: 0x1C with parity=1 -> one frame_err pulse, no flag, key_pressed unchanged. 0x1C with stop=0 -> same. A following good 0x32 -> key_pressed=8'h32 and a flag.
- Timeout and glitch: 5 bits, then idle for TIMEOUT_CYCLES -> frame_err pulse and FSM in IDLE; next good 0x1C is decoded correctly. A 2-cycle ps2_clk low glitch (FILTER_LEN=4) -> no bit sampled.
- Reset mid-frame: assert rst low for 1 clk after 4 data bits -> all outputs 0, no frame_err. Remaining bits are ignored until a new start bit; a subsequent full 0x1C frame -> flag.

Source files
------------

// File: rtl/ps2_key_receiver.sv
// ps2_key_receiver: PS/2 keyboard deframer and make/break decoder producing key_pressed/key_flag
module ps2_key_receiver #(
    parameter int FILTER_LEN      = 4,
    parameter int TIMEOUT_CYCLES  = 50000,
    parameter bit SUPPRESS_REPEAT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_pressed,
    output logic       key_flag,
    output logic       key_ext,
    output logic       frame_err
);
    localparam int FW = FILTER_LEN > 1 ? $clog2(FILTER_LEN) : 1;
    localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_s_q, dat_s_q;
    logic          fclk_q;
    logic [FW-1:0] flt_q;
    state_t        state_q;
    logic [2:0]    bit_q;
    logic [7:0]    sh_q, held_q, key_q;
    logic          par_q, brk_q, ext_q, held_v_q, flag_q, kext_q, err_q;
    logic [TW-1:0] to_q;
    logic          diff, toggle, fall, dat;

    assign dat    = dat_s_q[1];
    assign diff   = clk_s_q[1] != fclk_q;
    assign toggle = diff && flt_q == FW'(FILTER_LEN - 1);
    assign fall   = toggle && fclk_q;

    assign key_pressed = key_q;
    assign key_flag    = flag_q;
    assign key_ext     = kext_q;
    assign frame_err   = err_q;

    // two-flop synchronisers for both asynchronous PS/2 lines
    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_s_q <= 2'b11;
            dat_s_q <= 2'b11;
        end else begin
            clk_s_q <= {clk_s_q[0], ps2_clk};
            dat_s_q <= {dat_s_q[0], ps2_data};
        end
    end

    // filtered clock flips only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk) begin
        if (!rst) begin
            fclk_q <= 1'b1;
            flt_q  <= '0;
        end else if (toggle) begin
            fclk_q <= ~fclk_q;
            flt_q  <= '0;
        end else begin
            flt_q <= diff ? flt_q + 1'b1 : '0;
        end
    end

    // frame FSM with timeout, plus F0/E0 prefix decoder and repeat suppression
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            bit_q    <= '0;
            sh_q     <= '0;
            par_q    <= 1'b0;
            to_q     <= '0;
            brk_q    <= 1'b0;
            ext_q    <= 1'b0;
            held_q   <= '0;
            held_v_q <= 1'b0;
            key_q    <= '0;
            kext_q   <= 1'b0;
            flag_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            flag_q <= 1'b0;
            err_q  <= 1'b0;
            to_q   <= (state_q == IDLE || fall) ? '0 : to_q + 1'b1;
            if (state_q != IDLE && to_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_q <= IDLE;
                bit_q   <= '0;
                to_q    <= '0;
                err_q   <= 1'b1;
            end else if (fall) begin
                case (state_q)
                    IDLE: begin
                        if (dat) err_q <= 1'b1;
                        else begin
                            state_q <= DATA;
                            bit_q   <= '0;
                        end
                    end
                    DATA: begin
                        sh_q  <= {dat, sh_q[7:1]};
                        bit_q <= bit_q + 3'd1;
                        if (bit_q == 3'd7) state_q <= PARITY;
                    end
                    PARITY: begin
                        par_q   <= dat;
                        state_q <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        if (!dat || !(^{sh_q, par_q})) err_q <= 1'b1;
                        else if (sh_q == 8'hF0) brk_q <= 1'b1;
                        else if (sh_q == 8'hE0) ext_q <= 1'b1;
                        else if (brk_q) begin
                            if (held_v_q && sh_q == held_q) held_v_q <= 1'b0;
                            brk_q <= 1'b0;
                            ext_q <= 1'b0;
                        end else begin
                            if (!(SUPPRESS_REPEAT && held_v_q && sh_q == held_q)) begin
                                key_q    <= sh_q;
                                kext_q   <= ext_q;
                                flag_q   <= 1'b1;
                                held_q   <= sh_q;
                                held_v_q <= 1'b1;
                            end
                            ext_q <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_key_receiver.sv
// tb_ps2_key_receiver: scoreboard bench driving two receivers (repeat suppression on/off) from one PS/2 line
module tb_ps2_key_receiver;
    localparam int TO = 400;
    localparam int H  = 16;

    typedef struct {
        bit         err;
        logic [7:0] key;
        bit         ext;
        int         lo;
        int         hi;
    } ev_t;

    logic       clk = 1'b0, rst = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [7:0] kp0, kp1;
    logic       kf0, kf1, ke0, ke1, fe0, fe1;

    ev_t        q0[$], q1[$];
    int         cyc = 0, errors = 0, checks = 0;
    int         nf[2] = '{0, 0};
    bit         m_brk[2], m_ext[2], m_hv[2], m_kx[2];
    logic [7:0] m_held[2], m_key[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ps2_key_receiver #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TO), .SUPPRESS_REPEAT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_pressed(kp0), .key_flag(kf0), .key_ext(ke0), .frame_err(fe0));
    ps2_key_receiver #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TO), .SUPPRESS_REPEAT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_pressed(kp1), .key_flag(kf1), .key_ext(ke1), .frame_err(fe1));

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    task automatic push(input int s, input ev_t ev);
        if (s == 1) q1.push_back(ev);
        else q0.push_back(ev);
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_brk[s] = 0; m_ext[s] = 0; m_hv[s] = 0; m_kx[s] = 0;
            m_held[s] = 8'h00; m_key[s] = 8'h00;
        end
    endtask

    // frame-level reference: what each receiver should report for a completed frame
    task automatic model_byte(input logic [7:0] b, input bit ok);
        ev_t ev;
        for (int s = 0; s < 2; s++) begin
            ev.err = 0; ev.key = b; ev.ext = 0; ev.lo = cyc + 2; ev.hi = cyc + 12;
            if (!ok) begin
                ev.err = 1;
                push(s, ev);
            end else if (b == 8'hF0) m_brk[s] = 1;
            else if (b == 8'hE0) m_ext[s] = 1;
            else if (m_brk[s]) begin
                if (m_hv[s] && m_held[s] == b) m_hv[s] = 0;
                m_brk[s] = 0;
                m_ext[s] = 0;
            end else begin
                if (!(s == 1 && m_hv[s] && m_held[s] == b)) begin
                    ev.ext = m_ext[s];
                    push(s, ev);
                    m_key[s] = b; m_kx[s] = m_ext[s]; m_held[s] = b; m_hv[s] = 1;
                end
                m_ext[s] = 0;
            end
        end
    endtask

    task automatic mon(input int s, input logic f, input logic e, input logic [7:0] k, input logic x);
        ev_t ev;
        bit  have;
        if (f || e) begin
            chk($sformatf("dut%0d flag_and_err_together", s), {31'b0, f & e}, 0);
            have = (s == 1) ? q1.size() > 0 : q0.size() > 0;
            chk($sformatf("dut%0d event_expected", s), {31'b0, have}, 1);
            if (have) begin
                if (s == 1) ev = q1.pop_front();
                else ev = q0.pop_front();
                chk($sformatf("dut%0d frame_err", s), {31'b0, e}, {31'b0, ev.err});
                if (!ev.err) begin
                    chk($sformatf("dut%0d key_pressed", s), {24'b0, k}, {24'b0, ev.key});
                    chk($sformatf("dut%0d key_ext", s), {31'b0, x}, {31'b0, ev.ext});
                end
                chk($sformatf("dut%0d event_timing", s), {31'b0, cyc >= ev.lo && cyc <= ev.hi}, 1);
            end
            if (f) nf[s]++;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mon(0, kf0, fe0, kp0, ke0);
            mon(1, kf1, fe1, kp1, ke1);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bp, input bit bs);
        logic [10:0] fr;
        fr = {~bs, (~^b) ^ bp, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_data = fr[i];
            idle(H);
            if (i == 10) model_byte(b, !bp && !bs);
            ps2_clk = 1'b0;
            idle(H);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        idle(H);
    endtask

    task automatic partial(input logic [7:0] b, input int n, output int tf);
        logic [10:0] fr;
        fr = {1'b1, ~^b, b, 1'b0};
        tf = cyc;
        for (int i = 0; i < n; i++) begin
            ps2_data = fr[i];
            idle(H);
            tf = cyc;
            ps2_clk = 1'b0;
            idle(H);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic chk_zero(input string n);
        chk({n, " key_pressed0"}, {24'b0, kp0}, 0);
        chk({n, " key_pressed1"}, {24'b0, kp1}, 0);
        chk({n, " outs0"}, {29'b0, kf0, ke0, fe0}, 0);
        chk({n, " outs1"}, {29'b0, kf1, ke1, fe1}, 0);
    endtask

    initial begin
        int         tf, n0, n1, r;
        logic [7:0] b;
        logic [7:0] pool[6];
        ev_t        ev;
        pool = '{8'h1C, 8'h32, 8'h75, 8'h29, 8'hF0, 8'hE0};
        model_reset();
        idle(4);
        chk_zero("reset");
        rst = 1'b1;
        idle(8);

        n0 = nf[0]; n1 = nf[1];
        send_frame(8'h1C, 0, 0);
        chk("make key_pressed", {24'b0, kp1}, 32'h1C);
        chk("make key_ext", {31'b0, ke1}, 0);
        send_frame(8'h1C, 0, 0);
        send_frame(8'h1C, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1C, 0, 0);
        send_frame(8'h1C, 0, 0);
        chk("repeat flags suppress=1", nf[1] - n1, 2);
        chk("repeat flags suppress=0", nf[0] - n0, 4);
        chk("repeat key_pressed", {24'b0, kp1}, 32'h1C);

        send_frame(8'hE0, 0, 0);
        send_frame(8'h75, 0, 0);
        chk("ext key_pressed", {24'b0, kp1}, 32'h75);
        chk("ext key_ext", {31'b0, ke1}, 1);
        send_frame(8'h29, 0, 0);
        chk("plain key_pressed", {24'b0, kp1}, 32'h29);
        chk("plain key_ext", {31'b0, ke1}, 0);

        send_frame(8'h1C, 1, 0);
        send_frame(8'h1C, 0, 1);
        chk("err frames keep key", {24'b0, kp1}, 32'h29);
        send_frame(8'h32, 0, 0);
        chk("after err key_pressed", {24'b0, kp1}, 32'h32);

        partial(8'h1C, 5, tf);
        for (int s = 0; s < 2; s++) begin
            ev.err = 1; ev.key = 8'h00; ev.ext = 0; ev.lo = tf + TO; ev.hi = tf + TO + 20;
            push(s, ev);
        end
        idle(TO + 40);
        chk("timeout drained", q0.size() + q1.size(), 0);
        send_frame(8'h1C, 0, 0);
        chk("after timeout key_pressed", {24'b0, kp1}, 32'h1C);

        ps2_clk = 1'b0;
        idle(2);
        ps2_clk = 1'b1;
        idle(H);
        send_frame(8'h32, 0, 0);
        chk("after glitch key_pressed", {24'b0, kp0}, 32'h32);

        partial(8'h1C, 5, tf);
        rst = 1'b0;
        idle(1);
        chk_zero("midframe reset");
        rst = 1'b1;
        model_reset();
        chk("reset queues empty", q0.size() + q1.size(), 0);
        idle(H);
        n1 = nf[1];
        send_frame(8'h1C, 0, 0);
        chk("post reset flag", nf[1] - n1, 1);

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            b = (r < 6) ? pool[r] : 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                ps2_clk = 1'b0;
                idle($urandom_range(1, 2));
                ps2_clk = 1'b1;
                idle(H);
            end
            send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
        end

        idle(H);
        chk("queue0 drained", q0.size(), 0);
        chk("queue1 drained", q1.size(), 0);
        chk("final key0", {24'b0, kp0}, {24'b0, m_key[0]});
        chk("final key1", {24'b0, kp1}, {24'b0, m_key[1]});
        chk("final ext0", {31'b0, ke0}, {31'b0, m_kx[0]});
        chk("final ext1", {31'b0, ke1}, {31'b0, m_kx[1]});
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
